// File: rtl/wdt_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wdt_reset_ctrl
// Description : Watchdog reset controller. Turns timer overflows into a
//               warning interrupt and, if unserviced, a fixed-width system
//               reset pulse followed by a holdoff window. Optional warning
//               stage built only when WDT_RSTCTL_WARN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module wdt_reset_ctrl #(
    parameter int GRACE_CYCLES = 1024,
    parameter int PULSE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wdov,
    output logic       wdovclr,
    input  logic       irq_ack,
    output logic       warn_irq,
    output logic       sys_rst,
    input  logic       cause_clr,
    output logic       rst_cause,
    output logic [7:0] wd_cnt
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_warn  = 2'd1;
    localparam logic [1:0] c_st_reset = 2'd2;
    localparam logic [1:0] c_st_hold  = 2'd3;

    localparam logic [15:0] c_grace_m1 = 16'(GRACE_CYCLES - 1);
    localparam logic [15:0] c_pulse_m1 = 16'(PULSE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_ov_seen;
    logic        w_cnt_zero;
    logic        w_enter_warn;
    logic        w_enter_reset;
    logic        w_clr_nxt;

    // The timer flag is still high during the cycle we clear it; ignore it then.
    assign w_ov_seen  = wdov && !wdovclr;
    assign w_cnt_zero = (r_cnt == 16'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (w_ov_seen) begin
`ifdef WDT_RSTCTL_WARN_EN
                    w_state_nxt = c_st_warn;
                    w_cnt_nxt   = c_grace_m1;
`else
                    w_state_nxt = c_st_reset;
                    w_cnt_nxt   = c_pulse_m1;
`endif
                end
            end
`ifdef WDT_RSTCTL_WARN_EN
            c_st_warn: begin
                if (w_ov_seen) begin
                    w_state_nxt = c_st_reset;
                    w_cnt_nxt   = c_pulse_m1;
                end else if (irq_ack) begin
                    w_state_nxt = c_st_idle;
                end else if (w_cnt_zero) begin
                    w_state_nxt = c_st_reset;
                    w_cnt_nxt   = c_pulse_m1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
`endif
            c_st_reset: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_hold;
                    w_cnt_nxt   = c_pulse_m1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            c_st_hold: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    assign w_enter_warn  = (w_state_nxt == c_st_warn)  && (r_state != c_st_warn);
    assign w_enter_reset = (w_state_nxt == c_st_reset) && (r_state != c_st_reset);
    // With a one-cycle grace window both entries can fall back to back.
    assign w_clr_nxt     = (w_enter_warn || w_enter_reset) && !wdovclr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= 16'd0;
            wdovclr   <= 1'b0;
            sys_rst   <= 1'b0;
            rst_cause <= 1'b0;
            wd_cnt    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            wdovclr <= w_clr_nxt;
            sys_rst <= (w_state_nxt == c_st_reset);
            if (w_enter_reset) begin
                rst_cause <= 1'b1;
            end else if (cause_clr) begin
                rst_cause <= 1'b0;
            end
            if (w_enter_reset && (wd_cnt != 8'hFF)) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

`ifdef WDT_RSTCTL_WARN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            warn_irq <= 1'b0;
        end else begin
            warn_irq <= (w_state_nxt == c_st_warn);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{irq_ack, c_grace_m1, c_st_warn};
    assign warn_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wdt_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wdt_reset_ctrl
// Description : Scoreboard bench for wdt_reset_ctrl (GRACE=8, PULSE=4), with
//               a model of the timer overflow flag. Follows WDT_RSTCTL_WARN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wdt_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wdov;
    logic       wdovclr;
    logic       irq_ack = 1'b0;
    logic       warn_irq;
    logic       sys_rst;
    logic       cause_clr = 1'b0;
    logic       rst_cause;
    logic [7:0] wd_cnt;

    logic       ov_req = 1'b0;
    logic       r_flag = 1'b0;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic       e_cause = 1'b0;
    logic [7:0] e_cnt = 8'd0;

    wdt_reset_ctrl #(.GRACE_CYCLES(8), .PULSE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .wdov(wdov), .wdovclr(wdovclr),
        .irq_ack(irq_ack), .warn_irq(warn_irq), .sys_rst(sys_rst),
        .cause_clr(cause_clr), .rst_cause(rst_cause), .wd_cnt(wd_cnt)
    );

    always #5 clk = ~clk;

    // Timer overflow flag: a new overflow beats the clear.
    assign wdov = r_flag;
    always @(posedge clk) begin
        if (ov_req) r_flag <= 1'b1;
        else if (wdovclr) r_flag <= 1'b0;
    end

    // Monitor: one expectation per scheduled cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {wdovclr, warn_irq, sys_rst, rst_cause, wd_cnt};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s t=%0t: got clr/warn/srst=%03b cause=%b cnt=%0d, want clr/warn/srst=%03b cause=%b cnt=%0d",
                             e.name, $time, act[11:9], act[8], act[7:0],
                             e.exp[11:9], e.exp[8], e.exp[7:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input logic ov, input logic ack, input logic cclr, input logic r,
                       input bit chk, input logic [2:0] e, input string nm);
        exp_t x;
        ov_req    = ov;
        irq_ack   = ack;
        cause_clr = cclr;
        rst       = r;
        if (chk) begin
            x.name = nm;
            x.exp  = {e, e_cause, e_cnt};
            q.push_back(x);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic step(input logic [2:0] e, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e, nm);
    endtask

    task automatic steps(input int n, input logic [2:0] e, input string nm);
        for (int i = 0; i < n; i++) step(e, nm);
    endtask

    // Overflow from IDLE through to the first sys_rst cycle.
    task automatic enter_reset(input string nm);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, {nm, "_idle"});
`ifdef WDT_RSTCTL_WARN_EN
        step(3'b110, {nm, "_w1"});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, {nm, "_w2"});
`endif
        e_cause = 1'b1;
        if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
        step(3'b101, {nm, "_entry"});
    endtask

    task automatic force_rst(input string nm);
        enter_reset(nm);
        steps(3, 3'b001, {nm, "_pulse"});
        steps(4, 3'b000, {nm, "_hold"});
    endtask

    initial begin
        #2;
        // Reset held with the flag up.
        for (int i = 0; i < 3; i++) cyc(1'b1 * (i == 0), 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, "rst_hold");
`ifdef WDT_RSTCTL_WARN_EN
        step(3'b110, "rst_release_warn");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, "rst_ack");

        // Acknowledge in the third WARN cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "ack_idle");
        step(3'b110, "ack_w1");
        steps(2, 3'b010, "ack_w23");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, "ack_done");
        steps(3, 3'b000, "ack_no_reset");

        // Grace expiry, with an overflow arriving during holdoff.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "grace_idle");
        step(3'b110, "grace_w1");
        steps(7, 3'b010, "grace_warn");
        e_cause = 1'b1; e_cnt = 8'd1;
        step(3'b101, "grace_rst_entry");
        steps(3, 3'b001, "grace_pulse");
        step(3'b000, "hold_h1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "hold_ov_ignored");
        steps(2, 3'b000, "hold_h34");
        step(3'b000, "hold_then_idle");
        step(3'b110, "warn_after_hold");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, "ack_after_hold");

        // Second overflow and ack together: overflow wins.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "col_idle");
        step(3'b110, "col_w1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, "col_w2");
        e_cnt = 8'd2;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b101, "col_ov_ack");
        steps(3, 3'b001, "col_pulse");
        steps(4, 3'b000, "col_hold");

        // Ack on the final grace cycle: ack wins over expiry.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "az_idle");
        step(3'b110, "az_w1");
        steps(7, 3'b010, "az_warn");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, "ack_at_zero");
        steps(2, 3'b000, "az_idle_after");

        // cause_clr on the reset-entry edge loses to the set.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "cc_idle");
        step(3'b110, "cc_w1");
        steps(7, 3'b010, "cc_warn");
        e_cnt = 8'd3;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b101, "cclr_on_entry");
`else
        e_cause = 1'b1; e_cnt = 8'd1;
        step(3'b101, "rst_release_reset");
        steps(3, 3'b001, "rr_pulse");
        steps(4, 3'b000, "rr_hold");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, "ack_ignored");

        // Overflow during holdoff is held off until IDLE.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "nw_idle");
        e_cnt = 8'd2;
        step(3'b101, "nw_entry");
        steps(3, 3'b001, "nw_pulse");
        step(3'b000, "hold_h1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "hold_ov_ignored");
        steps(2, 3'b000, "hold_h34");
        step(3'b000, "hold_then_idle");
        e_cnt = 8'd3;
        step(3'b101, "rst_after_hold");
        steps(3, 3'b001, "rah_pulse");
        steps(4, 3'b000, "rah_hold");

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, "cc_idle");
        e_cnt = 8'd4;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b101, "cclr_on_entry");
`endif
        e_cause = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, "cclr_clears");
        steps(2, 3'b001, "cc_pulse");
        steps(4, 3'b000, "cc_hold");

        // Counter saturation.
        for (int i = 0; i < 256; i++) force_rst("sat");
        steps(2, 3'b000, "sat_idle");

        // Reset during the second sys_rst cycle.
        enter_reset("mid");
        step(3'b001, "mid_r2");
        e_cause = 1'b0; e_cnt = 8'd0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, "mid_rst");
        step(3'b000, "mid_post_idle");
        force_rst("post_mid");
        steps(2, 3'b000, "end_idle");

        #10;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
